tick_gen_multi: RTL and testbench
=================================

# tick_gen_multi

Multi-channel programmable tick generator, the parametrised successor to the single-channel clock divider used to pace the FSM labs. It provides CHANNELS independent down-counters of WIDTH bits, each with its own runtime-loadable divisor, periodic or one-shot mode, and start/stop control. It sits between the system clock and the FSM/counter blocks that need slow strobes, for example LED sequencers and reaction timers.

## Interface
- CHANNELS, default 4: number of independent tick channels (1..16).
- WIDTH, default 16: divisor/counter width in bits.
- DEFAULT_N, default 0: divisor value loaded into every channel at reset.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  global count enable (clock-enable prescale input).
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  $clog2(CHANNELS) (min 1)  channel addressed by the write.
- cfg_div  in  WIDTH  new divisor N; the period is N+1 enabled cycles.
- cfg_mode  in  1  0 = periodic, 1 = one-shot.
- start  in  CHANNELS  per-channel start request.
- stop  in  CHANNELS  per-channel stop request.
- sync  in  1  realign all running channels (present only with TICK_GEN_SYNC_EN).
- tick  out  CHANNELS  single-cycle tick pulse per channel, registered.
- running  out  CHANNELS  channel run flag, registered.

## Operation
- Per-channel state: div (WIDTH), count (WIDTH), mode (1), run (1), tick (1).
- Reset values: div = count = DEFAULT_N, mode = periodic, run = 0, tick = 0. This applies to every channel.
- Config write (cfg_we=1, cfg_ch<CHANNELS): the addressed channel gets div←cfg_div, mode←cfg_mode, count←cfg_div, tick←0. run is unchanged. A write with cfg_ch≥CHANNELS is ignored.
- start[i]: run←1, count←div. If a write addresses the same channel in the same cycle, count takes cfg_div.
- stop[i]: run←0, tick←0, count is held. stop has priority over start and over counting. A config write still applies.
- Counting happens when run=1, en=1 and there is no write, start or stop to that channel:
  - count==0: tick←1, count←div. In one-shot mode, run←0 as well.
  - otherwise: tick←0, count←count−1.
- When run=0 or en=0, tick←0 and count is held. No tick is produced while disabled.
- Counter arithmetic is unsigned, WIDTH bits. count never underflows because it reloads at 0. div=0 gives a tick on every enabled cycle.
- Per-channel priority: stop > config write > start > sync > count.

## Timing
- tick and running are registered, so there is no combinational path from any input to any output.
- After a start on edge k (running high after edge k), the first tick is asserted after enabled edge k+div+1. In periodic mode, ticks then repeat every div+1 enabled edges.
- Gaps in en stretch the period in real cycles but not in enabled cycles.
- In one-shot mode, running falls on the same edge that tick rises. Exactly one tick is produced.
- tick is high for exactly one cycle per expiry, unless div=0, en=1 and the mode is periodic, in which case it stays high continuously.
- A config write takes effect on the next edge. An in-flight period is abandoned and restarts from the new divisor.
- Reset mid-operation clears tick and running immediately (asynchronously). There are no pending starts.

## Configuration
- TICK_GEN_SYNC_EN defined:
  - The sync port exists.
  - On a cycle with sync=1, every channel with run=1 that is not stopped or written gets count←div and tick←0.
  - All running channels therefore become phase-aligned from that edge.
- TICK_GEN_SYNC_EN undefined:
  - The sync port and its logic are absent.
  - All other behaviour is identical.

## Structure
- Package tick_gen_pkg holds:
  - the typedef enum logic tick_mode_e {TICK_MODE_PERIODIC=0, TICK_MODE_ONESHOT=1};
  - a localparam function for the channel-index width, giving max(1, $clog2(CHANNELS)).
- Sub-module tick_gen_chan implements one channel (div, count, mode, run, tick and the priority logic). The top level decodes cfg_ch into a per-channel write-enable and instantiates CHANNELS copies with a generate loop.

## Test plan
- Reset, then write ch0 div=3 periodic, start[0], en=1 → tick[0] pulses on the 4th, 8th and 12th edge after start. running[0]=1 throughout.
- ch1 div=2 one-shot, start → a single tick on the 3rd edge after start, running[1] falls on the same edge, and there are no further ticks over 20 cycles.
- ch2 div=5 periodic with en toggling 1,0,1,0 → ticks every 6 enabled edges (12 clock edges), and tick stays low while en=0.
- Assert start[0] and stop[0] together while ch0 is running → running[0]=0 next edge and no ticks afterwards. Separately, write cfg_ch=CHANNELS → no channel changes.
- Assert rst mid-period on channels 0–3 → tick=0 and running=0 immediately. After release, counts equal DEFAULT_N and no tick appears without start.
- With TICK_GEN_SYNC_EN: ch0 div=3 and ch1 div=3 started 2 cycles apart, then pulse sync → from the next period the two channels tick on identical edges.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared types and helpers for the multi-channel tick generator.
package tick_gen_pkg;

    typedef enum logic {
        TICK_MODE_PERIODIC = 1'b0,
        TICK_MODE_ONESHOT  = 1'b1
    } tick_mode_e;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int ch_idx_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/tick_gen_chan.sv
// One tick channel: divisor, down-counter, mode and run flag with
// per-channel priority stop > config write > start > sync > count.
module tick_gen_chan
    import tick_gen_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] DEFAULT_N = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [WIDTH-1:0] i_cfg_div,
    input  logic             i_cfg_mode,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_sync,
    output logic             o_tick,
    output logic             o_running
);

    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_count;
    tick_mode_e       r_mode;
    logic             r_run;
    logic             r_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div   <= DEFAULT_N;
            r_count <= DEFAULT_N;
            r_mode  <= TICK_MODE_PERIODIC;
            r_run   <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            // A write lands even when a stop wins the rest of the cycle.
            if (i_we) begin
                r_div  <= i_cfg_div;
                r_mode <= tick_mode_e'(i_cfg_mode);
            end

            if (i_stop) begin
                r_run  <= 1'b0;
                r_tick <= 1'b0;
                if (i_we) r_count <= i_cfg_div;
            end else if (i_we) begin
                r_count <= i_cfg_div;
                r_tick  <= 1'b0;
                if (i_start) r_run <= 1'b1;
            end else if (i_start) begin
                r_run   <= 1'b1;
                r_count <= r_div;
                r_tick  <= 1'b0;
            end else if (i_sync && r_run) begin
                r_count <= r_div;
                r_tick  <= 1'b0;
            end else if (r_run && i_en) begin
                if (r_count == '0) begin
                    r_tick  <= 1'b1;
                    r_count <= r_div;
                    if (r_mode == TICK_MODE_ONESHOT) r_run <= 1'b0;
                end else begin
                    r_tick  <= 1'b0;
                    r_count <= r_count - 1'b1;
                end
            end else begin
                r_tick <= 1'b0;
            end
        end
    end

    assign o_tick    = r_tick;
    assign o_running = r_run;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator (CHANNELS x tick_gen_chan).
// Define TICK_GEN_SYNC_EN to add the sync port that realigns running channels.
module tick_gen_multi
    import tick_gen_pkg::*;
#(
    parameter int               CHANNELS  = 4,
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] DEFAULT_N = '0,
    localparam int              CW        = ch_idx_w(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                cfg_we,
    input  logic [CW-1:0]       cfg_ch,
    input  logic [WIDTH-1:0]    cfg_div,
    input  logic                cfg_mode,
    input  logic [CHANNELS-1:0] start,
    input  logic [CHANNELS-1:0] stop,
`ifdef TICK_GEN_SYNC_EN
    input  logic                sync,
`endif
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] running
);

    logic                w_sync;
    logic [CHANNELS-1:0] w_we;

`ifdef TICK_GEN_SYNC_EN
    assign w_sync = sync;
`else
    assign w_sync = 1'b0;
`endif

    // Out-of-range selects match no channel, so such writes are dropped.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign w_we[g] = cfg_we && (cfg_ch == CW'(g));

        tick_gen_chan #(
            .WIDTH     (WIDTH),
            .DEFAULT_N (DEFAULT_N)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .i_en       (en),
            .i_we       (w_we[g]),
            .i_cfg_div  (cfg_div),
            .i_cfg_mode (cfg_mode),
            .i_start    (start[g]),
            .i_stop     (stop[g]),
            .i_sync     (w_sync),
            .o_tick     (tick[g]),
            .o_running  (running[g])
        );
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed self-checking bench for tick_gen_multi (5 channels, DEFAULT_N=2).
module tb_tick_gen_multi;

    localparam int               CH = 5;
    localparam int               W  = 16;
    localparam int               CW = 3;
    localparam logic [W-1:0]     DN = 16'd2;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          cfg_we;
    logic [CW-1:0] cfg_ch;
    logic [W-1:0]  cfg_div;
    logic          cfg_mode;
    logic [CH-1:0] start;
    logic [CH-1:0] stop;
    logic          sync;
    logic [CH-1:0] tick;
    logic [CH-1:0] running;

    logic [CH-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_errors = 0;

    tick_gen_multi #(
        .CHANNELS  (CH),
        .WIDTH     (W),
        .DEFAULT_N (DN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_mode (cfg_mode),
        .start    (start),
        .stop     (stop),
`ifdef TICK_GEN_SYNC_EN
        .sync     (sync),
`endif
        .tick     (tick),
        .running  (running)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [CW-1:0] ch, input logic [W-1:0] d, input logic m);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_div  = d;
        cfg_mode = m;
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic pulse_start(input logic [CH-1:0] m);
        start = m;
        step();
        start = '0;
    endtask

    task automatic stop_all();
        stop = '1;
        step();
        stop = '0;
    endtask

    // scoreboard: one expected tick vector per upcoming edge
    task automatic drain(input string tag);
        int n;
        logic [CH-1:0] e;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            step();
            e = exp_q.pop_front();
            check(tag, tick, e);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
        cfg_mode = 1'b0; start = '0; stop = '0; sync = 1'b0;

        // reset state
        #12;
        check("rst_tick", tick, 0);
        check("rst_run", running, 0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;

        // ch0 periodic div=3: ticks on edges 4, 8, 12 after start
        write_cfg(3'd0, 16'd3, 1'b0);
        pulse_start(5'b00001);
        check("t1_run_start", running, 5'b00001);
        for (int j = 1; j <= 12; j++) exp_q.push_back((j % 4 == 0) ? 5'b00001 : 5'b00000);
        drain("t1_tick");
        check("t1_run_end", running, 5'b00001);
        stop_all();

        // ch1 one-shot div=2: single tick on edge 3, running falls with it
        write_cfg(3'd1, 16'd2, 1'b1);
        pulse_start(5'b00010);
        check("t2_run_start", running, 5'b00010);
        for (int j = 1; j <= 23; j++) begin
            logic [CH-1:0] e;
            step();
            e = (j == 3) ? 5'b00010 : 5'b00000;
            check("t2_tick", tick, e);
            check("t2_run", running, (j < 3) ? 5'b00010 : 5'b00000);
        end
        stop_all();

        // ch2 periodic div=5 with en alternating: ticks on clock edges 11 and 23
        write_cfg(3'd2, 16'd5, 1'b0);
        pulse_start(5'b00100);
        for (int j = 1; j <= 24; j++) begin
            logic [CH-1:0] e;
            en = (j % 2 == 1);
            step();
            e = (j == 11 || j == 23) ? 5'b00100 : 5'b00000;
            check("t3_tick", tick, e);
        end
        en = 1'b1;
        stop_all();

        // start and stop together: stop wins
        pulse_start(5'b00001);
        step();
        start = 5'b00001;
        stop  = 5'b00001;
        step();
        start = '0;
        stop  = '0;
        check("t4_stop_run", running, 0);
        check("t4_stop_tick", tick, 0);
        for (int j = 1; j <= 8; j++) exp_q.push_back('0);
        drain("t4_idle");

        // out-of-range writes change nothing; ch3/ch4 still hold DEFAULT_N
        write_cfg(3'd5, 16'd0, 1'b1);
        write_cfg(3'd7, 16'd0, 1'b1);
        pulse_start(5'b11010);
        for (int j = 1; j <= 9; j++) begin
            if (j == 3)                exp_q.push_back(5'b11010);
            else if (j == 6 || j == 9) exp_q.push_back(5'b11000);
            else                       exp_q.push_back(5'b00000);
        end
        drain("t4_badwr_tick");
        check("t4_badwr_run", running, 5'b11000);
        stop_all();

        // div=0 periodic: tick held high while enabled, drops with en=0
        write_cfg(3'd2, 16'd0, 1'b0);
        pulse_start(5'b00100);
        for (int j = 1; j <= 5; j++) exp_q.push_back(5'b00100);
        drain("t5_div0_tick");
        en = 1'b0;
        step();
        check("t5_div0_en0", tick, 0);
        en = 1'b1;
        stop_all();

        // asynchronous reset mid-period clears outputs immediately
        pulse_start(5'b11111);
        step();
        step();
        check("t6_pre_run", running, 5'b11111);
        check("t6_pre_tick", tick, 5'b00100);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_tick", tick, 0);
        check("t6_async_run", running, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 1; j <= 8; j++) exp_q.push_back('0);
        drain("t6_idle_tick");
        check("t6_idle_run", running, 0);
        pulse_start(5'b11111);
        for (int j = 1; j <= 6; j++) exp_q.push_back((j % 3 == 0) ? 5'b11111 : 5'b00000);
        drain("t6_default_tick");
        check("t6_default_run", running, 5'b11111);
        stop_all();

`ifdef TICK_GEN_SYNC_EN
        // ch0/ch1 started two edges apart, then realigned by sync
        write_cfg(3'd0, 16'd3, 1'b0);
        write_cfg(3'd1, 16'd3, 1'b0);
        pulse_start(5'b00001);
        step();
        pulse_start(5'b00010);
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("t7_sync_tick", tick, 0);
        for (int j = 1; j <= 8; j++) exp_q.push_back((j % 4 == 0) ? 5'b00011 : 5'b00000);
        drain("t7_aligned_tick");
        stop_all();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
